// File: rtl/apb_fifo_slave_if.sv
// APB signal bundle between the system APB master and apb_fifo_slave.
interface apb_fifo_slave_if #(
  parameter int DATA_WIDTH      = 32,
  parameter int MAIN_ADDR_WIDTH = 32
);
  logic [MAIN_ADDR_WIDTH-1:0] PADDR;
  logic                       PSEL;
  logic                       PENABLE;
  logic                       PWRITE;
  logic [DATA_WIDTH-1:0]      PWDATA;
  logic [DATA_WIDTH/8-1:0]    PSTRB;
  logic                       PREADY;
  logic [DATA_WIDTH-1:0]      PRDATA;
  logic                       PSLVERR;

  modport master (
    output PADDR, PSEL, PENABLE, PWRITE, PWDATA, PSTRB,
    input  PREADY, PRDATA, PSLVERR
  );

  modport slave (
    input  PADDR, PSEL, PENABLE, PWRITE, PWDATA, PSTRB,
    output PREADY, PRDATA, PSLVERR
  );
endinterface

// File: rtl/apb_fifo_slave.sv
// APB mailbox slave: FIFO_DEPTH-entry FIFO, STATUS, CTRL and THRESH registers, wait states, level irq.
// Optional APB_FIFO_SLAVE_SLVERR_EN drives PSLVERR; otherwise it is tied low.
module apb_fifo_slave #(
  parameter int DATA_WIDTH      = 32,
  parameter int MAIN_ADDR_WIDTH = 32,
  parameter int FIFO_DEPTH      = 8,
  parameter int WAIT_CYCLES     = 1
) (
  input  logic            PCLK,
  input  logic            PRESET_n,
  apb_fifo_slave_if.slave apb,
  output logic            irq
);
  localparam int CW  = $clog2(FIFO_DEPTH) + 1;
  localparam int AW  = CW - 1;
  localparam int SW  = DATA_WIDTH / 8;
  localparam int WCW = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;
  localparam logic [WCW-1:0] WAIT_VAL = WCW'(WAIT_CYCLES);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2
  } state_t;

  state_t                r_state;
  state_t                w_phase;
  state_t                w_next;
  logic [WCW-1:0]        r_wcnt;
  logic [CW-1:0]         r_wr_ptr;
  logic [CW-1:0]         r_rd_ptr;
  logic [CW-1:0]         r_thresh;
  logic                  r_irq_en;
  logic [DATA_WIDTH-1:0] r_mem [FIFO_DEPTH];

  logic [CW-1:0]         w_count;
  logic                  w_full;
  logic                  w_empty;
  logic                  w_sel_en;
  logic                  w_pready;
  logic                  w_err;
  logic [1:0]            w_reg;
  logic                  w_wr_ok;
  logic                  w_push;
  logic                  w_pop;
  logic                  w_ctrl_wr;
  logic                  w_thresh_wr;
  logic                  w_flush;
  logic [DATA_WIDTH-1:0] w_rdata;
  logic                  w_unused_addr;

  function automatic logic access_error(
    input logic [1:0] addr_lo,
    input logic [1:0] reg_sel,
    input logic       write,
    input logic       strb_full,
    input logic       full,
    input logic       empty
  );
    logic e;
    e = (addr_lo != 2'd0);
    case (reg_sel)
      2'd0:    e = e | (write ? (!strb_full | full) : empty);
      2'd1:    e = e | write;
      default: e = e;
    endcase
    return e;
  endfunction

  assign w_unused_addr = ^apb.PADDR[MAIN_ADDR_WIDTH-1:4];

  assign w_count  = r_wr_ptr - r_rd_ptr;
  assign w_empty  = (r_wr_ptr == r_rd_ptr);
  assign w_full   = (r_wr_ptr[AW] != r_rd_ptr[AW]) && (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign w_sel_en = apb.PSEL && apb.PENABLE;
  assign w_pready = (r_state == ST_ACCESS) && w_sel_en && (r_wcnt == WAIT_VAL);
  assign w_reg    = apb.PADDR[3:2];
  assign w_err    = access_error(apb.PADDR[1:0], w_reg, apb.PWRITE, &apb.PSTRB, w_full, w_empty);

  assign w_wr_ok     = w_pready && apb.PWRITE && !w_err;
  assign w_push      = w_wr_ok && (w_reg == 2'd0);
  assign w_ctrl_wr   = w_wr_ok && (w_reg == 2'd2);
  assign w_thresh_wr = w_wr_ok && (w_reg == 2'd3);
  assign w_flush     = w_ctrl_wr && apb.PSTRB[0] && apb.PWDATA[0];
  assign w_pop       = w_pready && !apb.PWRITE && !w_err && (w_reg == 2'd0);

  // Bus phase and next state; the setup phase is recognised in the cycle the master presents it.
  always_comb begin
    w_phase = r_state;
    w_next  = ST_IDLE;
    if ((r_state != ST_ACCESS) && apb.PSEL && !apb.PENABLE) begin
      w_phase = ST_SETUP;
    end else begin
      w_phase = r_state;
    end
    case (w_phase)
      ST_IDLE:   w_next = ST_IDLE;
      ST_SETUP:  w_next = ST_ACCESS;
      ST_ACCESS: begin
        if (!w_sel_en || w_pready) begin
          w_next = ST_IDLE;
        end else begin
          w_next = ST_ACCESS;
        end
      end
      default:   w_next = ST_IDLE;
    endcase
  end

  // FSM state register.
  always_ff @(posedge PCLK or negedge PRESET_n) begin
    if (!PRESET_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Wait-state counter: cleared in setup, counts stalled access cycles.
  always_ff @(posedge PCLK or negedge PRESET_n) begin
    if (!PRESET_n) begin
      r_wcnt <= '0;
    end else if (w_phase == ST_SETUP) begin
      r_wcnt <= '0;
    end else if ((w_phase == ST_ACCESS) && w_sel_en && !w_pready) begin
      r_wcnt <= r_wcnt + WCW'(1);
    end else begin
      r_wcnt <= r_wcnt;
    end
  end

  // FIFO pointers and control/threshold registers; all updates gated by a clean completion.
  always_ff @(posedge PCLK or negedge PRESET_n) begin
    if (!PRESET_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_irq_en <= 1'b0;
      r_thresh <= '0;
    end else begin
      if (w_flush) begin
        r_wr_ptr <= '0;
        r_rd_ptr <= '0;
      end else begin
        if (w_push) r_wr_ptr <= r_wr_ptr + CW'(1);
        if (w_pop)  r_rd_ptr <= r_rd_ptr + CW'(1);
      end
      if (w_ctrl_wr && apb.PSTRB[0]) r_irq_en <= apb.PWDATA[1];
      for (int i = 0; i < CW; i++) begin
        if (w_thresh_wr && apb.PSTRB[i/8]) r_thresh[i] <= apb.PWDATA[i];
      end
    end
  end

  // FIFO storage; the pointers alone define which entries are valid.
  always_ff @(posedge PCLK) begin
    if (w_push) r_mem[r_wr_ptr[AW-1:0]] <= apb.PWDATA;
  end

  // Read mux: zero unless a clean read is completing this cycle.
  always_comb begin
    w_rdata = '0;
    if (w_pready && !apb.PWRITE && !w_err) begin
      case (w_reg)
        2'd0:    w_rdata = r_mem[r_rd_ptr[AW-1:0]];
        2'd1:    w_rdata = DATA_WIDTH'({w_count, w_full, w_empty});
        2'd2:    w_rdata = DATA_WIDTH'({r_irq_en, 1'b0});
        2'd3:    w_rdata = DATA_WIDTH'(r_thresh);
        default: w_rdata = '0;
      endcase
    end else begin
      w_rdata = '0;
    end
  end

  assign apb.PREADY = w_pready;
  assign apb.PRDATA = w_rdata;
`ifdef APB_FIFO_SLAVE_SLVERR_EN
  assign apb.PSLVERR = w_pready && w_err;
`else
  assign apb.PSLVERR = 1'b0;
`endif

  assign irq = r_irq_en && (w_count >= r_thresh) && (r_thresh != '0);

  logic w_unused_strb;
  assign w_unused_strb = (SW > 0) ? 1'b0 : 1'b1;
endmodule

// File: tb/tb_apb_fifo_slave.sv
// Self-checking bench for apb_fifo_slave: directed scenarios plus randomized traffic against a queue model.
module tb_apb_fifo_slave;
  localparam int DW    = 32;
  localparam int AWID  = 32;
  localparam int DEPTH = 8;
  localparam int WAITS = 1;
`ifdef APB_FIFO_SLAVE_SLVERR_EN
  localparam bit SLVERR_EN = 1'b1;
`else
  localparam bit SLVERR_EN = 1'b0;
`endif

  logic PCLK = 1'b0;
  logic PRESET_n;
  logic irq;
  int   vectors = 0;
  int   miscompares = 0;

  apb_fifo_slave_if #(.DATA_WIDTH(DW), .MAIN_ADDR_WIDTH(AWID)) apb ();

  apb_fifo_slave #(
    .DATA_WIDTH(DW), .MAIN_ADDR_WIDTH(AWID), .FIFO_DEPTH(DEPTH), .WAIT_CYCLES(WAITS)
  ) dut (
    .PCLK(PCLK), .PRESET_n(PRESET_n), .apb(apb.slave), .irq(irq)
  );

  always #5 PCLK = ~PCLK;

  // Reference model: mailbox contents as a queue plus the two software registers.
  logic [31:0] m_q[$];
  bit          m_irq_en;
  logic [3:0]  m_thresh;

  task automatic model_reset();
    m_q.delete();
    m_irq_en = 1'b0;
    m_thresh = 4'd0;
  endtask

  function automatic bit m_irq();
    return m_irq_en && (m_thresh != 4'd0) && (m_q.size() >= int'(m_thresh));
  endfunction

  task automatic model_apply(input bit wr, input logic [31:0] addr, input logic [31:0] data,
                             input logic [3:0] strb, output logic [31:0] exp_rd, output bit exp_err);
    int r;
    r = int'(addr[3:2]);
    exp_rd = 32'd0;
    exp_err = (addr[1:0] != 2'd0) || (wr && r == 1) ||
              (wr && r == 0 && (strb != 4'hF || m_q.size() == DEPTH)) ||
              (!wr && r == 0 && m_q.size() == 0);
    if (!exp_err) begin
      if (wr) begin
        case (r)
          0: m_q.push_back(data);
          2: if (strb[0]) begin
               m_irq_en = data[1];
               if (data[0]) m_q.delete();
             end
          3: if (strb[0]) m_thresh = data[3:0];
          default: ;
        endcase
      end else begin
        case (r)
          0: exp_rd = m_q.pop_front();
          1: exp_rd = 32'(m_q.size() * 4) | ((m_q.size() == DEPTH) ? 32'd2 : 32'd0) |
                      ((m_q.size() == 0) ? 32'd1 : 32'd0);
          2: exp_rd = {30'd0, m_irq_en, 1'b0};
          3: exp_rd = {28'd0, m_thresh};
          default: exp_rd = 32'd0;
        endcase
      end
    end
  endtask

  // One APB transfer starting at the next rising edge; returns at the negedge of the completing cycle.
  task automatic apb_xfer(input bit wr, input logic [31:0] addr, input logic [31:0] data,
                          input logic [3:0] strb, output logic [31:0] rd, output logic err,
                          output int waits);
    bit done;
    done = 1'b0;
    waits = 0;
    rd = 32'd0;
    err = 1'b0;
    @(posedge PCLK); #1;
    apb.PSEL = 1'b1; apb.PENABLE = 1'b0; apb.PWRITE = wr;
    apb.PADDR = addr; apb.PWDATA = data; apb.PSTRB = strb;
    @(posedge PCLK); #1;
    apb.PENABLE = 1'b1;
    for (int i = 0; i < 16 && !done; i++) begin
      @(negedge PCLK);
      if (apb.PREADY === 1'b1) begin
        rd = apb.PRDATA; err = apb.PSLVERR; done = 1'b1;
      end else begin
        waits++;
        vectors++;
        if (apb.PRDATA !== 32'd0) begin
          miscompares++; $display("FAIL prdata_while_wait: got %h expected 00000000", apb.PRDATA);
        end
      end
    end
    if (!done) begin
      vectors++; miscompares++;
      $display("FAIL pready_timeout: PREADY never rose within 16 cycles (addr %h)", addr);
    end
  endtask

  task automatic apb_idle();
    @(posedge PCLK); #1;
    apb.PSEL = 1'b0; apb.PENABLE = 1'b0;
    @(negedge PCLK);
  endtask

  task automatic test_reset();
    logic [31:0] rd, exp;
    logic err;
    bit xerr;
    int w;
    apb.PSEL = 1'b0; apb.PENABLE = 1'b0; apb.PWRITE = 1'b0;
    apb.PADDR = 32'd0; apb.PWDATA = 32'd0; apb.PSTRB = 4'd0;
    PRESET_n = 1'b0;
    model_reset();
    repeat (3) @(posedge PCLK);
    @(negedge PCLK);
    vectors++; if (apb.PREADY !== 1'b0) begin miscompares++; $display("FAIL reset_pready: got %b expected 0", apb.PREADY); end
    vectors++; if (apb.PRDATA !== 32'd0) begin miscompares++; $display("FAIL reset_prdata: got %h expected 0", apb.PRDATA); end
    vectors++; if (apb.PSLVERR !== 1'b0) begin miscompares++; $display("FAIL reset_pslverr: got %b expected 0", apb.PSLVERR); end
    vectors++; if (irq !== 1'b0) begin miscompares++; $display("FAIL reset_irq: got %b expected 0", irq); end
    PRESET_n = 1'b1;
    apb_xfer(1'b0, 32'h4, 32'd0, 4'h0, rd, err, w);
    model_apply(1'b0, 32'h4, 32'd0, 4'h0, exp, xerr);
    vectors++; if (rd !== 32'h1) begin miscompares++; $display("FAIL reset_status: got %h expected 00000001", rd); end
    vectors++; if (err !== 1'b0) begin miscompares++; $display("FAIL reset_status_err: got %b expected 0", err); end
    vectors++; if (w != WAITS) begin miscompares++; $display("FAIL wait_states: got %0d expected %0d", w, WAITS); end
  endtask

  task automatic test_fill_drain();
    logic [31:0] rd, exp;
    logic err;
    bit xerr;
    int w;
    for (int i = 0; i <= DEPTH; i++) begin
      logic [31:0] d;
      d = (i < DEPTH) ? (32'hA5A5_0001 + 32'(i)) : 32'hDEAD_BEEF;
      apb_xfer(1'b1, 32'h0, d, 4'hF, rd, err, w);
      model_apply(1'b1, 32'h0, d, 4'hF, exp, xerr);
      vectors++; if (err !== (SLVERR_EN & xerr)) begin miscompares++; $display("FAIL push_err[%0d]: got %b expected %b", i, err, SLVERR_EN & xerr); end
      vectors++; if (w != WAITS) begin miscompares++; $display("FAIL push_waits[%0d]: got %0d expected %0d", i, w, WAITS); end
    end
    apb_xfer(1'b0, 32'h4, 32'd0, 4'h0, rd, err, w);
    model_apply(1'b0, 32'h4, 32'd0, 4'h0, exp, xerr);
    vectors++; if (rd !== exp || exp !== 32'h22) begin miscompares++; $display("FAIL full_status: got %h expected %h", rd, exp); end
    for (int i = 0; i < DEPTH; i++) begin
      apb_xfer(1'b0, 32'h0, 32'd0, 4'h0, rd, err, w);
      model_apply(1'b0, 32'h0, 32'd0, 4'h0, exp, xerr);
      vectors++; if (rd !== exp) begin miscompares++; $display("FAIL pop_data[%0d]: got %h expected %h", i, rd, exp); end
    end
    apb_xfer(1'b0, 32'h4, 32'd0, 4'h0, rd, err, w);
    model_apply(1'b0, 32'h4, 32'd0, 4'h0, exp, xerr);
    vectors++; if (rd !== 32'h1) begin miscompares++; $display("FAIL drained_status: got %h expected 00000001", rd); end
    apb_idle();
  endtask

  task automatic test_empty_pop();
    logic [31:0] rd, exp;
    logic err;
    bit xerr;
    int w;
    apb_xfer(1'b0, 32'h0, 32'd0, 4'h0, rd, err, w);
    model_apply(1'b0, 32'h0, 32'd0, 4'h0, exp, xerr);
    vectors++; if (rd !== 32'd0) begin miscompares++; $display("FAIL empty_pop_data: got %h expected 0", rd); end
    vectors++; if (err !== SLVERR_EN) begin miscompares++; $display("FAIL empty_pop_err: got %b expected %b", err, SLVERR_EN); end
    apb_xfer(1'b0, 32'h4, 32'd0, 4'h0, rd, err, w);
    model_apply(1'b0, 32'h4, 32'd0, 4'h0, exp, xerr);
    vectors++; if (rd !== 32'h1) begin miscompares++; $display("FAIL empty_pop_status: got %h expected 00000001", rd); end
    apb_idle();
  endtask

  task automatic test_irq();
    logic [31:0] rd, exp;
    logic err;
    bit xerr;
    int w;
    apb_xfer(1'b1, 32'hC, 32'd3, 4'hF, rd, err, w);
    model_apply(1'b1, 32'hC, 32'd3, 4'hF, exp, xerr);
    apb_xfer(1'b1, 32'h8, 32'h2, 4'hF, rd, err, w);
    model_apply(1'b1, 32'h8, 32'h2, 4'hF, exp, xerr);
    for (int i = 0; i < 3; i++) begin
      apb_xfer(1'b1, 32'h0, $urandom, 4'hF, rd, err, w);
      vectors++; if (irq !== 1'b0) begin miscompares++; $display("FAIL irq_early[%0d]: got %b expected 0", i, irq); end
      model_apply(1'b1, 32'h0, 32'd0, 4'hF, exp, xerr);
    end
    apb_idle();
    vectors++; if (irq !== 1'b1 || !m_irq()) begin miscompares++; $display("FAIL irq_rise: got %b expected 1", irq); end
    apb_xfer(1'b0, 32'h0, 32'd0, 4'h0, rd, err, w);
    model_apply(1'b0, 32'h0, 32'd0, 4'h0, exp, xerr);
    apb_idle();
    vectors++; if (irq !== 1'b0) begin miscompares++; $display("FAIL irq_fall: got %b expected 0", irq); end
  endtask

  task automatic test_flush();
    logic [31:0] rd, exp;
    logic err;
    bit xerr;
    int w;
    for (int i = 0; i < 5; i++) begin
      logic [31:0] d;
      d = $urandom;
      apb_xfer(1'b1, 32'h0, d, 4'hF, rd, err, w);
      model_apply(1'b1, 32'h0, d, 4'hF, exp, xerr);
    end
    apb_xfer(1'b1, 32'h8, 32'h1, 4'hF, rd, err, w);
    model_apply(1'b1, 32'h8, 32'h1, 4'hF, exp, xerr);
    apb_xfer(1'b0, 32'h4, 32'd0, 4'h0, rd, err, w);
    model_apply(1'b0, 32'h4, 32'd0, 4'h0, exp, xerr);
    vectors++; if (rd !== 32'h1) begin miscompares++; $display("FAIL flush_status: got %h expected 00000001", rd); end
    apb_xfer(1'b0, 32'h8, 32'd0, 4'h0, rd, err, w);
    model_apply(1'b0, 32'h8, 32'd0, 4'h0, exp, xerr);
    vectors++; if (rd !== exp) begin miscompares++; $display("FAIL ctrl_readback: got %h expected %h", rd, exp); end
    apb_xfer(1'b1, 32'h0, 32'h1234_5678, 4'h3, rd, err, w);
    model_apply(1'b1, 32'h0, 32'h1234_5678, 4'h3, exp, xerr);
    vectors++; if (err !== SLVERR_EN) begin miscompares++; $display("FAIL partial_strb_err: got %b expected %b", err, SLVERR_EN); end
    apb_xfer(1'b0, 32'h4, 32'd0, 4'h0, rd, err, w);
    model_apply(1'b0, 32'h4, 32'd0, 4'h0, exp, xerr);
    vectors++; if (rd !== 32'h1) begin miscompares++; $display("FAIL partial_strb_nopush: got %h expected 00000001", rd); end
    apb_idle();
  endtask

  task automatic test_psel_drop();
    logic [31:0] rd, exp;
    logic err;
    bit xerr;
    int w;
    @(posedge PCLK); #1;
    apb.PSEL = 1'b1; apb.PENABLE = 1'b0; apb.PWRITE = 1'b1;
    apb.PADDR = 32'h0; apb.PWDATA = 32'hCAFE_0001; apb.PSTRB = 4'hF;
    @(posedge PCLK); #1;
    apb.PENABLE = 1'b1;
    @(posedge PCLK); #1;
    apb.PSEL = 1'b0; apb.PENABLE = 1'b0;
    @(negedge PCLK);
    vectors++; if (apb.PREADY !== 1'b0) begin miscompares++; $display("FAIL psel_drop_pready: got %b expected 0", apb.PREADY); end
    apb_xfer(1'b0, 32'h4, 32'd0, 4'h0, rd, err, w);
    model_apply(1'b0, 32'h4, 32'd0, 4'h0, exp, xerr);
    vectors++; if (rd !== exp) begin miscompares++; $display("FAIL psel_drop_status: got %h expected %h", rd, exp); end
    apb_idle();
  endtask

  task automatic test_reset_mid();
    logic [31:0] rd, exp;
    logic err;
    bit xerr;
    int w;
    apb_xfer(1'b1, 32'hC, 32'd1, 4'hF, rd, err, w);
    model_apply(1'b1, 32'hC, 32'd1, 4'hF, exp, xerr);
    apb_xfer(1'b1, 32'h8, 32'h2, 4'hF, rd, err, w);
    model_apply(1'b1, 32'h8, 32'h2, 4'hF, exp, xerr);
    apb_xfer(1'b1, 32'h0, 32'h0BAD_F00D, 4'hF, rd, err, w);
    model_apply(1'b1, 32'h0, 32'h0BAD_F00D, 4'hF, exp, xerr);
    @(posedge PCLK); #1;
    apb.PSEL = 1'b1; apb.PENABLE = 1'b0; apb.PWRITE = 1'b1; apb.PADDR = 32'h0; apb.PWDATA = 32'h1; apb.PSTRB = 4'hF;
    @(posedge PCLK); #1;
    apb.PENABLE = 1'b1;
    vectors++; if (irq !== 1'b1) begin miscompares++; $display("FAIL pre_reset_irq: got %b expected 1", irq); end
    @(negedge PCLK);
    PRESET_n = 1'b0;
    #1;
    model_reset();
    vectors++; if (apb.PREADY !== 1'b0) begin miscompares++; $display("FAIL mid_reset_pready: got %b expected 0", apb.PREADY); end
    vectors++; if (irq !== 1'b0) begin miscompares++; $display("FAIL mid_reset_irq: got %b expected 0", irq); end
    @(posedge PCLK); #1;
    apb.PSEL = 1'b0; apb.PENABLE = 1'b0;
    @(negedge PCLK);
    PRESET_n = 1'b1;
    apb_xfer(1'b0, 32'h4, 32'd0, 4'h0, rd, err, w);
    model_apply(1'b0, 32'h4, 32'd0, 4'h0, exp, xerr);
    vectors++; if (rd !== 32'h1) begin miscompares++; $display("FAIL post_reset_status: got %h expected 00000001", rd); end
    apb_xfer(1'b0, 32'hC, 32'd0, 4'h0, rd, err, w);
    model_apply(1'b0, 32'hC, 32'd0, 4'h0, exp, xerr);
    vectors++; if (rd !== 32'd0) begin miscompares++; $display("FAIL post_reset_thresh: got %h expected 0", rd); end
    apb_idle();
  endtask

  task automatic test_random();
    logic [31:0] rd, exp, addr, data;
    logic [3:0] strb;
    logic err;
    bit xerr, wr;
    int w, r;
    for (int n = 0; n < 300; n++) begin
      r    = $urandom_range(0, 3);
      wr   = 1'($urandom_range(0, 1));
      addr = ($urandom & 32'hFFFF_FFF0) | 32'(r * 4);
      if ($urandom_range(0, 7) == 0) addr = addr | 32'($urandom_range(1, 3));
      data = $urandom;
      if (r == 3) data = 32'($urandom_range(0, 9));
      if (r == 2) data = (data & 32'hFFFF_FFFE) | (($urandom_range(0, 7) == 0) ? 32'd1 : 32'd0);
      strb = ($urandom_range(0, 7) == 0) ? 4'($urandom) : 4'hF;
      apb_xfer(wr, addr, data, strb, rd, err, w);
      model_apply(wr, addr, data, strb, exp, xerr);
      vectors++; if (err !== (SLVERR_EN & xerr)) begin miscompares++; $display("FAIL rand_err[%0d]: got %b expected %b", n, err, SLVERR_EN & xerr); end
      if (!wr) begin
        vectors++; if (rd !== exp) begin miscompares++; $display("FAIL rand_rdata[%0d]: addr %h got %h expected %h", n, addr, rd, exp); end
      end
      if ($urandom_range(0, 1) == 1) begin
        apb_idle();
        vectors++; if (irq !== m_irq()) begin miscompares++; $display("FAIL rand_irq[%0d]: got %b expected %b", n, irq, m_irq()); end
      end
    end
    apb_idle();
  endtask

  initial begin
    test_reset();
    test_fill_drain();
    test_empty_pop();
    test_irq();
    test_flush();
    test_psel_drop();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
